// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, flag indices, condition codes and FSM states for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_ASR  = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_LAND = 4'hB;
    localparam logic [3:0] OP_LOR  = 4'hC;
    localparam logic [3:0] OP_LNOT = 4'hD;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    // Reserved codes 8..D and NV never pass.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic pass;
        case (cond)
            COND_EQ: pass = flags[FLAG_Z];
            COND_NE: pass = !flags[FLAG_Z];
            COND_CS: pass = flags[FLAG_C];
            COND_CC: pass = !flags[FLAG_C];
            COND_MI: pass = flags[FLAG_N];
            COND_PL: pass = !flags[FLAG_N];
            COND_VS: pass = flags[FLAG_V];
            COND_VC: pass = !flags[FLAG_V];
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// rtl/alu_seq_rf.sv - register file, two sync read ports, one write port, async debug read, r0 = 0
module alu_seq_rf
    import alu_seq_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [31:0]       rd1,
    output logic [31:0]       rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [31:0]       wd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    logic [31:0] regs [NREG];

    // Read registers only load on rd_en, so they hold the operands between instructions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (we && (wa != '0)) begin
                regs[wa] <= wd;
            end
            if (rd_en) begin
                rd1 <= (ra1 == '0) ? '0 : regs[ra1];
                rd2 <= (ra2 == '0) ? '0 : regs[ra2];
            end
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - ALU issue/writeback sequencer; ALU_SEQ_COND_EN adds conditional writeback
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_oprt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_use_imm,
`ifdef ALU_SEQ_COND_EN
    input  logic [3:0]        in_cond,
`endif
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    output logic [3:0]        alu_oprt,
    output logic              alu_en,
    input  logic [31:0]       alu_res,
    input  logic [10:0]       alu_flag,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rd,
    output logic [31:0]       out_res,
    output logic [3:0]        out_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    state_t state_q, state_d;

    logic [3:0]        ir_oprt;
    logic [ADDR_W-1:0] ir_rd, ir_rs1, ir_rs2;
    logic [31:0]       ir_imm;
    logic              ir_use_imm;
    logic [3:0]        oprt_q;
    logic [31:0]       imm_q;
    logic              use_imm_q;
    logic [31:0]       res_q;
    logic [3:0]        flag_q;
    logic [31:0]       rf_rd1, rf_rd2;
    logic              accept, cond_ok, wb_we;
    logic              unused_flag_hi;

    assign unused_flag_hi = ^alu_flag[10:4];

`ifdef ALU_SEQ_COND_EN
    logic [3:0] ir_cond;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_cond <= '0;
        end else if (accept) begin
            ir_cond <= in_cond;
        end
    end

    // Evaluated against the previous instruction's flags, not this one's.
    assign cond_ok = cond_pass(ir_cond, flag_q);
`else
    assign cond_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        alu_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_READ;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_en  = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                out_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign wb_we  = out_valid & cond_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_oprt    <= '0;
            ir_rd      <= '0;
            ir_rs1     <= '0;
            ir_rs2     <= '0;
            ir_imm     <= '0;
            ir_use_imm <= 1'b0;
            oprt_q     <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            res_q      <= '0;
            flag_q     <= '0;
        end else begin
            if (accept) begin
                ir_oprt    <= in_oprt;
                ir_rd      <= in_rd;
                ir_rs1     <= in_rs1;
                ir_rs2     <= in_rs2;
                ir_imm     <= in_imm;
                ir_use_imm <= in_use_imm;
            end
            // Loaded alongside the RF read so the ALU lines change only on entry to EXEC.
            if (state_q == ST_READ) begin
                oprt_q    <= ir_oprt;
                imm_q     <= ir_imm;
                use_imm_q <= ir_use_imm;
            end
            if (state_q == ST_EXEC) begin
                res_q <= alu_res;
            end
            if (wb_we) begin
                flag_q <= alu_flag[3:0];
            end
        end
    end

    alu_seq_rf #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (state_q == ST_READ),
        .ra1      (ir_rs1),
        .ra2      (ir_rs2),
        .rd1      (rf_rd1),
        .rd2      (rf_rd2),
        .we       (wb_we),
        .wa       (ir_rd),
        .wd       (res_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_op1  = rf_rd1;
    assign alu_op2  = use_imm_q ? imm_q : rf_rd2;
    assign alu_oprt = oprt_q;

    assign out_rd   = out_valid ? ir_rd : '0;
    assign out_res  = out_valid ? res_q : '0;
    assign out_flag = out_valid ? (cond_ok ? alu_flag[3:0] : flag_q) : '0;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq with an ALU model and reference model
module tb_alu_seq;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  cond;
    } instr_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic [3:0]  flag;
        logic [3:0]  rd;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_use_imm;
    logic [3:0]  in_oprt, in_rd, in_rs1, in_rs2, in_cond;
    logic [31:0] in_imm;
    logic [31:0] alu_op1, alu_op2, alu_res;
    logic [3:0]  alu_oprt;
    logic        alu_en;
    logic [10:0] alu_flag = 11'h550;
    logic        out_valid;
    logic [3:0]  out_rd, out_flag;
    logic [31:0] out_res;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [35:0] alu_now;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mrf [16];
    logic [3:0]  mflag;
    instr_t      prog_q[$];
    exp_t        exp_q[$];
    logic [31:0] last_res;
    logic [3:0]  last_flag, last_rd;
    logic [3:0]  ops [12] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_oprt    (in_oprt),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
`ifdef ALU_SEQ_COND_EN
        .in_cond    (in_cond),
`endif
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_oprt   (alu_oprt),
        .alu_en     (alu_en),
        .alu_res    (alu_res),
        .alu_flag   (alu_flag),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .out_res    (out_res),
        .out_flag   (out_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Returns {V,C,Z,N,res}.
    function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h4: r = a >> b[4:0];
            4'h5: r = a << b[4:0];
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = ~a;
            4'h9: r = $unsigned($signed(a) >>> b[4:0]);
            4'hA: r = a ^ b;
            4'hB: r = {31'd0, (a != 0) && (b != 0)};
            4'hC: r = {31'd0, (a != 0) || (b != 0)};
            4'hD: r = {31'd0, a == 0};
            default: r = 32'd0;
        endcase
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {v, cy, z, n} = f;
        case (c)
            0: return z;
            1: return !z;
            2: return cy;
            3: return !cy;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU stand-in: combinational result while enabled, flags registered.
    assign alu_now = alu_calc(alu_oprt, alu_op1, alu_op2);
    assign alu_res = alu_en ? alu_now[31:0] : 32'hDEADBEEF;
    always @(posedge clk) if (alu_en) alu_flag <= {7'h55, alu_now[35:32]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mrf[i] = 32'd0;
        mflag = 4'd0;
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [31:0] imm, input logic use_imm, input logic [3:0] cond);
        instr_t t;
        t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.use_imm = use_imm; t.cond = cond;
        prog_q.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            check(tag, dbg_data, (i == 0) ? 32'd0 : mrf[i]);
        end
        @(negedge clk);
    endtask

    // Plays prog_q with in_valid held high; called and returns at a negedge.
    task automatic run_prog();
        int budget, prev_acc;
        exp_t e;
        instr_t t;
        logic [35:0] r;
        logic ok;
        budget = 8 * prog_q.size() + 20;
        prev_acc = -1;
        while ((prog_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            if (exp_q.size() > 0) begin
                check("alu_en", alu_en, cyc == exp_q[0].acc + 1);
                if (cyc == exp_q[0].acc + 1) begin
                    check("alu_op1", alu_op1, exp_q[0].op1);
                    check("alu_op2", alu_op2, exp_q[0].op2);
                    check("alu_oprt", alu_oprt, exp_q[0].op);
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc - e.acc, 2);
                    check("out_rd", out_rd, e.rd);
                    check("out_res", out_res, e.res);
                    check("out_flag", out_flag, e.flag);
                    last_res = out_res;
                    last_flag = out_flag;
                    last_rd = out_rd;
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].acc + 2) begin
                check("missing_valid", out_valid, 1);
                void'(exp_q.pop_front());
            end
            if (prog_q.size() > 0) begin
                t = prog_q[0];
                in_valid = 1'b1;
                in_oprt = t.op; in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2;
                in_imm = t.imm; in_use_imm = t.use_imm; in_cond = t.cond;
                if (in_ready) begin
                    void'(prog_q.pop_front());
                    if (prev_acc >= 0) check("accept_spacing", cyc + 1 - prev_acc, 4);
                    prev_acc = cyc + 1;
                    e.op  = t.op;
                    e.op1 = (t.rs1 == 0) ? 32'd0 : mrf[t.rs1];
                    e.op2 = t.use_imm ? t.imm : ((t.rs2 == 0) ? 32'd0 : mrf[t.rs2]);
                    r = alu_calc(t.op, e.op1, e.op2);
`ifdef ALU_SEQ_COND_EN
                    ok = cond_holds(t.cond, mflag);
`else
                    ok = 1'b1;
`endif
                    e.res  = r[31:0];
                    e.flag = ok ? r[35:32] : mflag;
                    e.rd   = t.rd;
                    e.acc  = cyc + 1;
                    if (ok) begin
                        if (t.rd != 0) mrf[t.rd] = r[31:0];
                        mflag = r[35:32];
                    end
                    exp_q.push_back(e);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        check("drain", prog_q.size() + exp_q.size(), 0);
        prog_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cnd;
        in_oprt = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_use_imm = 0; in_cond = 0;
        dbg_addr = 0;
        last_res = 0; last_flag = 0; last_rd = 0;
        do_reset();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_out_res", out_res, 0);
        check_rf("rst_dbg");

        // Carry into zero
        push(4'h0, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 4'hE);
        push(4'h0, 4'd2, 4'd1, 4'd0, 32'hFFFFFFFB, 1'b1, 4'hE);
        run_prog();
        check("t2_res", last_res, 32'd0);
        check("t2_flag", last_flag, 4'b0110);

        // Signed overflow
        push(4'h0, 4'd1, 4'd0, 4'd0, 32'h7FFFFFFF, 1'b1, 4'hE);
        push(4'h0, 4'd2, 4'd0, 4'd0, 32'd1, 1'b1, 4'hE);
        push(4'h0, 4'd3, 4'd1, 4'd2, 32'hABCD0000, 1'b0, 4'hE);
        run_prog();
        check("t3_res", last_res, 32'h80000000);
        check("t3_flag", last_flag, 4'b1001);

        // Write to r0
        push(4'h0, 4'd0, 4'd0, 4'd0, 32'd7, 1'b1, 4'hE);
        run_prog();
        check("t4_res", last_res, 32'd7);
        check("t4_rd", last_rd, 0);
        check_rf("t4_dbg");

        // Randomized stream with in_valid held
        for (int i = 0; i < 40; i++) begin
`ifdef ALU_SEQ_COND_EN
            cnd = $urandom_range(0, 15);
`else
            cnd = 4'hE;
`endif
            push(ops[$urandom_range(0, 11)], $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom, $urandom_range(0, 1), cnd);
        end
        run_prog();
        check_rf("rand_dbg");

        // Reset during EXEC
        in_oprt = 4'h0; in_rd = 4'd6; in_rs1 = 0; in_rs2 = 0; in_imm = 32'h55; in_use_imm = 1; in_cond = 4'hE;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_in_exec", alu_en, 1);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        model_clear();
        check("t6_in_ready", in_ready, 1);
        check("t6_alu_en", alu_en, 0);
        check("t6_alu_op1", alu_op1, 0);
        check("t6_alu_oprt", alu_oprt, 0);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_valid", out_valid, 0);
            @(negedge clk);
        end
        check_rf("t6_dbg");

`ifdef ALU_SEQ_COND_EN
        // Z=1 from SUB: NE write suppressed, then EQ write performed
        push(4'h1, 4'd1, 4'd1, 4'd1, 32'd0, 1'b0, 4'hE);
        push(4'h0, 4'd4, 4'd0, 4'd0, 32'd3, 1'b1, 4'h1);
        push(4'h0, 4'd5, 4'd0, 4'd0, 32'd9, 1'b1, 4'h0);
        run_prog();
        dbg_addr = 4'd4;
        #1;
        check("cond_ne_r4", dbg_data, 32'd0);
        dbg_addr = 4'd5;
        #1;
        check("cond_eq_r5", dbg_data, 32'd9);
        @(negedge clk);
        check_rf("cond_dbg");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
